// File: rtl/ifu.sv
// Single-outstanding instruction fetch unit: owns the PC, fetches one word at a
// time over a valid/ready memory channel and hands {inst, pc} to decode.
module ifu #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic [31:0] out_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halt,
   output logic        halted,
   output logic [31:0] fetch_count
);

   typedef enum logic [2:0] {
      ST_BOOT   = 3'd0,
      ST_REQ    = 3'd1,
      ST_WAIT   = 3'd2,
      ST_HOLD   = 3'd3,
      ST_HALTED = 3'd4
   } state_t;

   state_t      state_r;
   logic [31:0] pc_r;
   logic        kill_r;
   logic        halt_pend_r;
   logic [31:0] target_s;

   assign target_s = redirect_pc & ~32'd3;

   // Handshake strobes decode the state register only, so no input reaches them combinationally.
   assign imem_req_valid = (state_r == ST_REQ);
   assign out_valid      = (state_r == ST_HOLD);
   assign halted         = (state_r == ST_HALTED);
   assign imem_req_addr  = pc_r;

   // Fetch FSM together with the PC, kill/halt tracking, output latch and handshake counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_BOOT;
         pc_r        <= RESET_PC;
         kill_r      <= 1'b0;
         halt_pend_r <= 1'b0;
         out_inst    <= 32'd0;
         out_pc      <= 32'd0;
         fetch_count <= 32'd0;
      end else begin
         case (state_r)
            ST_BOOT: begin
               state_r <= ST_REQ;
            end
            ST_REQ: begin
               if (halt) begin
                  // An accepted request still owes a response; absorb it before stopping.
                  if (imem_req_ready) begin
                     state_r     <= ST_WAIT;
                     kill_r      <= 1'b1;
                     halt_pend_r <= 1'b1;
                  end else begin
                     state_r <= ST_HALTED;
                  end
               end else if (redirect_valid) begin
                  pc_r <= target_s;
                  if (imem_req_ready) begin
                     state_r <= ST_WAIT;
                     kill_r  <= 1'b1;
                  end else begin
                     state_r <= ST_REQ;
                  end
               end else if (imem_req_ready) begin
                  state_r <= ST_WAIT;
                  kill_r  <= 1'b0;
               end else begin
                  state_r <= ST_REQ;
               end
            end
            ST_WAIT: begin
               if (redirect_valid) begin
                  pc_r   <= target_s;
                  kill_r <= 1'b1;
               end else begin
                  pc_r <= pc_r;
               end
               if (halt) begin
                  kill_r      <= 1'b1;
                  halt_pend_r <= 1'b1;
               end else begin
                  halt_pend_r <= halt_pend_r;
               end
               if (imem_rsp_valid) begin
                  if (halt_pend_r || halt) begin
                     state_r <= ST_HALTED;
                  end else if (kill_r || redirect_valid) begin
                     kill_r  <= 1'b0;
                     state_r <= ST_REQ;
                  end else begin
                     out_inst <= imem_rsp_data;
                     out_pc   <= pc_r;
                     state_r  <= ST_HOLD;
                  end
               end else begin
                  state_r <= ST_WAIT;
               end
            end
            ST_HOLD: begin
               if (halt) begin
                  state_r <= ST_HALTED;
               end else if (redirect_valid) begin
                  pc_r    <= target_s;
                  state_r <= ST_REQ;
               end else if (out_ready) begin
                  fetch_count <= fetch_count + 32'd1;
                  pc_r        <= pc_r + 32'd4;
                  state_r     <= ST_REQ;
               end else begin
                  state_r <= ST_HOLD;
               end
            end
            ST_HALTED: begin
               state_r <= ST_HALTED;
            end
            default: begin
               state_r <= ST_HALTED;
            end
         endcase
      end
   end

endmodule

// File: doc/ifu.md
# ifu

Single-outstanding instruction fetch unit for the NPC core. Holds the architectural PC, issues one read per instruction to instruction memory over a valid/ready request channel, captures the response, and presents a registered `{inst, pc}` pair to decode and the ebreak/halt detector through a valid/ready output channel. It accepts PC redirects from execute and a halt request from the ebreak path, after which it stops fetching until reset.

## Interface
- `RESET_PC`, 32'h8000_0000, PC loaded on reset.
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts request this cycle.
- `imem_req_addr`  out  32  fetch address (= PC register, bits [1:0] always 0).
- `imem_rsp_valid`  in  1  response data valid (one cycle pulse, never in the acceptance cycle).
- `imem_rsp_data`  in  32  instruction word.
- `out_valid`  out  1  `out_inst`/`out_pc` valid.
- `out_ready`  in  1  downstream consumes this cycle.
- `out_inst`  out  32  fetched instruction.
- `out_pc`  out  32  address of `out_inst`.
- `redirect_valid`  in  1  one-cycle pulse: next fetch from `redirect_pc`.
- `redirect_pc`  in  32  target; bits [1:0] ignored (forced 0).
- `halt`  in  1  level; stop fetching (from ebreak detection).
- `halted`  out  1  FSM is in HALTED.
- `fetch_count`  out  32  number of `out` handshakes since reset, wraps at 2^32.

## Operation
- States: BOOT, REQ, WAIT, HOLD, HALTED. Registers: `pc`, `kill`, `out_inst`, `out_pc`, `fetch_count`, state.
- Reset (async, rst_n=0): state=BOOT, pc=RESET_PC, kill=0, out_inst=0, out_pc=0, fetch_count=0. Outputs: imem_req_valid=0, out_valid=0, halted=0, imem_req_addr=RESET_PC.
- BOOT: unconditionally -> REQ next cycle (halt/redirect ignored).
- REQ: imem_req_valid=1, addr=pc. Priority halt > redirect > accept.
  - halt=1 -> HALTED; a request accepted this same cycle is tracked: go WAIT with kill=1 instead, then HALTED on its response.
  - redirect_valid=1: pc<=redirect_pc&~3; if imem_req_ready=1 the old-address request is in flight -> WAIT with kill=1; else stay REQ.
  - imem_req_ready=1 -> WAIT, kill=0.
- WAIT: imem_req_valid=0. redirect_valid=1 -> pc<=target, kill<=1. halt=1 latched into kill as well and marks halt pending.
  - On imem_rsp_valid: if halt pending/halt=1 -> HALTED (data discarded). Else if kill (or redirect_valid same cycle) -> discard, kill<=0, -> REQ. Else out_inst<=rsp_data, out_pc<=pc, -> HOLD.
- HOLD: out_valid=1, outputs stable until handshake.
  - halt=1 -> HALTED, out_valid drops, no handshake counted even if out_ready=1.
  - redirect_valid=1 -> pc<=target, -> REQ, entry dropped (redirect wins over out_ready; not counted).
  - out_ready=1 -> fetch_count+=1, pc<=pc+4 (mod 2^32), -> REQ.
- HALTED: imem_req_valid=0, out_valid=0, halted=1; all inputs ignored until reset.
- pc+4 wraps 0xFFFF_FFFC -> 0x0000_0000 silently.

## Timing
- imem_req_valid, out_valid, halted are pure decodes of the state register (no input-to-output combinational path).
- Best-case per instruction: REQ accept (cycle 0), rsp (cycle 1), out_valid high cycle 2, handshake cycle 2, next REQ cycle 3 -> 3 cycles/inst.
- out_inst/out_pc change only on WAIT->HOLD transition.
- Redirect to first request on new address: 1 cycle from REQ/HOLD; after the in-flight response from WAIT.
- Halt in HOLD: out_valid low next cycle. Reset mid-transaction: immediate, in-flight response after reset release is not expected and undefined.

## Test plan
- Reset release, imem_req_ready=1, rsp 1 cycle later with 0x00000013, out_ready=1 -> first req addr 0x80000000 on cycle 1 after BOOT, out_pc=0x80000000, out_inst=0x00000013, next addr 0x80000004, fetch_count=1.
- Backpressure: out_ready=0 for 5 cycles in HOLD -> out_valid held, out_inst/out_pc stable, no new imem request, fetch_count unchanged.
- Redirect in WAIT to 0x80000103 -> old response discarded (no out_valid), next req addr 0x80000100.
- Redirect and out_ready same cycle in HOLD -> no handshake counted, next req addr = target.
- halt in HOLD with ebreak 0x00100073 presented -> out_valid low next cycle, halted=1, no further imem_req_valid for 20 cycles despite redirects.
- pc=0xFFFFFFFC fetch accepted by out -> next req addr 0x00000000.
